// File: rtl/afe_pkg.sv
// rtl/afe_pkg.sv - shared AFE types and constants (scheduler and calibration controller)
package afe_pkg;

   localparam int         ADC_W         = 8;
   localparam logic [6:0] DC_COMP_RESET = 7'd64;

   typedef enum logic [1:0] {IDLE, SETTLE, ACQ, PUSH} afe_state_t;
   typedef enum logic [1:0] {DARK, IR, RED} afe_slot_t;

endpackage

// File: rtl/afe_channel_scheduler_if.sv
// rtl/afe_channel_scheduler_if.sv - settings, ADC, LED/DAC/PGA drive and sample stream of the scheduler
interface afe_channel_scheduler_if;
   import afe_pkg::*;

   logic             enable;
   logic [6:0]       dc_ir;
   logic [6:0]       dc_red;
   logic [3:0]       pga_ir;
   logic [3:0]       pga_red;
   logic [ADC_W-1:0] ADC;
   logic             adc_valid;
   logic             sample_ready;
   logic             LED_IR;
   logic             LED_RED;
   logic [6:0]       DC_Comp;
   logic [3:0]       PGA_Gain;
   logic [ADC_W-1:0] sample_data;
   logic             sample_chan;
   logic             sample_valid;
   logic             busy;

   modport slave (
      input  enable, dc_ir, dc_red, pga_ir, pga_red, ADC, adc_valid, sample_ready,
      output LED_IR, LED_RED, DC_Comp, PGA_Gain, sample_data, sample_chan, sample_valid, busy
   );

   modport master (
      output enable, dc_ir, dc_red, pga_ir, pga_red, ADC, adc_valid, sample_ready,
      input  LED_IR, LED_RED, DC_Comp, PGA_Gain, sample_data, sample_chan, sample_valid, busy
   );

endinterface

// File: rtl/afe_avg_acc.sv
// rtl/afe_avg_acc.sv - burst accumulator and shift-average for one slot
// AFE_AMBIENT_SUB_EN: keeps the dark average and subtracts it (saturating at 0) from LED averages.
module afe_avg_acc
   import afe_pkg::*;
#(
   parameter int AVG_LOG2 = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             acq,
   input  logic [ADC_W-1:0] adc,
   input  logic             adc_valid,
`ifdef AFE_AMBIENT_SUB_EN
   input  logic             is_dark,
`endif
   output logic             done,
   output logic [ADC_W-1:0] avg
);

   localparam int ACC_W = ADC_W + AVG_LOG2;
   localparam int NUM   = 1 << AVG_LOG2;

   logic [AVG_LOG2:0] cnt;
   logic [ACC_W-1:0]  acc;
   logic              full;
   logic [ADC_W-1:0]  mean;

   assign full = (cnt == (AVG_LOG2 + 1)'(NUM));
   assign mean = ADC_W'(acc >> AVG_LOG2);

`ifdef AFE_AMBIENT_SUB_EN
   logic [ADC_W-1:0] dark_q;
`endif

   // done is a single-cycle pulse one edge after the last sample lands, with avg already updated
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         acc  <= '0;
         done <= 1'b0;
         avg  <= '0;
`ifdef AFE_AMBIENT_SUB_EN
         dark_q <= '0;
`endif
      end else if (clear) begin
         cnt  <= '0;
         acc  <= '0;
         done <= 1'b0;
      end else begin
         if (acq && !full && adc_valid) begin
            acc <= acc + ACC_W'(adc);
            cnt <= cnt + (AVG_LOG2 + 1)'(1);
         end
         done <= acq && full && !done;
         if (acq && full && !done) begin
`ifdef AFE_AMBIENT_SUB_EN
            if (is_dark)
               dark_q <= mean;
            else
               avg <= (mean > dark_q) ? mean - dark_q : '0;
`else
            avg <= mean;
`endif
         end
      end
   end

endmodule

// File: rtl/afe_channel_scheduler.sv
// rtl/afe_channel_scheduler.sv - IR/RED time-multiplexing of the shared optical front end
// AFE_AMBIENT_SUB_EN: inserts a dark (LEDs off) slot before every LED slot for ambient subtraction.
module afe_channel_scheduler
   import afe_pkg::*;
#(
   parameter int SETTLE_CYC = 16,
   parameter int AVG_LOG2   = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   afe_channel_scheduler_if.slave  bus
);

   localparam int CNT_W = $clog2(SETTLE_CYC + 1);
`ifdef AFE_AMBIENT_SUB_EN
   localparam bit HAS_DARK = 1'b1;
`else
   localparam bit HAS_DARK = 1'b0;
`endif

   afe_state_t       state_q, state_d;
   afe_slot_t        slot_q, slot_d;
   logic             chan_q, chan_d;
   logic [CNT_W-1:0] settle_cnt;
   logic             start_slot, push_entry, avg_done;
   logic [ADC_W-1:0] avg;

   logic             led_ir_q, led_red_q, chan_out_q, valid_q, busy_q;
   logic [6:0]       dc_q;
   logic [3:0]       pga_q;
   logic [ADC_W-1:0] data_q;

   // chan tracks the LED channel the current slot belongs to; a dark slot borrows it for its settings
   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      chan_d     = chan_q;
      start_slot = 1'b0;
      push_entry = 1'b0;
      unique case (state_q)
         IDLE: if (bus.enable) begin
            state_d    = SETTLE;
            start_slot = 1'b1;
            chan_d     = 1'b0;
            slot_d     = HAS_DARK ? DARK : IR;
         end
         SETTLE: if (settle_cnt == CNT_W'(SETTLE_CYC - 1)) state_d = ACQ;
         ACQ: if (avg_done) begin
            if (slot_q == DARK) begin
               state_d    = SETTLE;
               start_slot = 1'b1;
               slot_d     = chan_q ? RED : IR;
            end else begin
               state_d    = PUSH;
               push_entry = 1'b1;
            end
         end
         PUSH: if (bus.sample_ready) begin
            if (bus.enable) begin
               state_d    = SETTLE;
               start_slot = 1'b1;
               chan_d     = ~chan_q;
               slot_d     = HAS_DARK ? DARK : (chan_q ? IR : RED);
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         slot_q     <= IR;
         chan_q     <= 1'b0;
         settle_cnt <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         chan_q  <= chan_d;
         if (start_slot)
            settle_cnt <= '0;
         else if (state_q == SETTLE)
            settle_cnt <= settle_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_ir_q   <= 1'b0;
         led_red_q  <= 1'b0;
         dc_q       <= DC_COMP_RESET;
         pga_q      <= '0;
         data_q     <= '0;
         chan_out_q <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         busy_q <= (state_d != IDLE);
         if (start_slot) begin
            led_ir_q  <= (slot_d == IR);
            led_red_q <= (slot_d == RED);
            dc_q      <= chan_d ? bus.dc_red  : bus.dc_ir;
            pga_q     <= chan_d ? bus.pga_red : bus.pga_ir;
         end else if (state_d == IDLE) begin
            led_ir_q  <= 1'b0;
            led_red_q <= 1'b0;
            dc_q      <= DC_COMP_RESET;
            pga_q     <= '0;
         end
         if (push_entry) begin
            led_ir_q   <= 1'b0;
            led_red_q  <= 1'b0;
            data_q     <= avg;
            chan_out_q <= chan_q;
            valid_q    <= 1'b1;
         end else if (state_q == PUSH && bus.sample_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   afe_avg_acc #(.AVG_LOG2(AVG_LOG2)) u_avg_acc (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (state_q == SETTLE),
      .acq       (state_q == ACQ),
      .adc       (bus.ADC),
      .adc_valid (bus.adc_valid),
`ifdef AFE_AMBIENT_SUB_EN
      .is_dark   (slot_q == DARK),
`endif
      .done      (avg_done),
      .avg       (avg)
   );

   assign bus.LED_IR       = led_ir_q;
   assign bus.LED_RED      = led_red_q;
   assign bus.DC_Comp      = dc_q;
   assign bus.PGA_Gain     = pga_q;
   assign bus.sample_data  = data_q;
   assign bus.sample_chan  = chan_out_q;
   assign bus.sample_valid = valid_q;
   assign bus.busy         = busy_q;

endmodule
